// File: rtl/ibex_rf_wr_pkg.sv
// ----------------------------------------------------------------------------
// ibex_rf_wr_pkg
// Shared types for the register-file write-side control stage:
//   rf_addr_t    - architectural register address (5 bit)
//   wb_src_e     - which source owns the register-file write port this cycle
//   LoadDepthMax - upper bound for the outstanding-load FIFO depth
// ----------------------------------------------------------------------------
package ibex_rf_wr_pkg;

    localparam int unsigned RfAddrW      = 5;
    localparam int unsigned LoadDepthMax = 4;

    typedef logic [RfAddrW-1:0] rf_addr_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_LOAD,
        WB_SKID,
        WB_EX
    } wb_src_e;

endpackage

// File: rtl/ibex_rf_wr_ctrl_ld_fifo.sv
// ----------------------------------------------------------------------------
// ibex_rf_ld_fifo
// Destination-register FIFO for outstanding loads. Entry order matches load
// issue order, so the head always names the register of the next response.
// Illegal pushes (full) and pops (empty) are ignored here; the parent flags
// them.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   push_i, push_rd_i - enqueue a load destination
//   pop_i           - dequeue the head (load response arrived)
//   full_o, empty_o - occupancy status
//   head_rd_o       - destination of the oldest outstanding load
//   head_mask_o     - one-hot position of the head (zero when empty)
//   entry_valid_o   - per-entry occupancy
//   entry_rd_o      - per-entry destination, entry i at [i*5 +: 5]
// ----------------------------------------------------------------------------
module ibex_rf_ld_fifo
    import ibex_rf_wr_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [4:0]                 push_rd_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [4:0]                 head_rd_o,
    output logic [Depth-1:0]           head_mask_o,
    output logic [Depth-1:0]           entry_valid_o,
    output logic [Depth*RfAddrW-1:0]   entry_rd_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    rf_addr_t        rd_q [Depth];
    logic            push_ok, pop_ok;
    logic [PtrW-1:0] walk_ptr;

    // Pointers wrap at Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    assign head_rd_o = rd_q[rptr_q];

    always_comb begin
        wptr_d = push_ok ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop_ok ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Entry validity is derived from read pointer and count: the first cnt_q
    // slots starting at the head are occupied.
    always_comb begin
        entry_valid_o = '0;
        head_mask_o   = '0;
        entry_rd_o    = '0;
        walk_ptr      = rptr_q;
        for (int k = 0; k < Depth; k++) begin
            if (CntW'(k) < cnt_q) begin
                entry_valid_o[walk_ptr] = 1'b1;
            end
            walk_ptr = ptr_inc(walk_ptr);
        end
        if (!empty_o) begin
            head_mask_o[rptr_q] = 1'b1;
        end
        for (int i = 0; i < Depth; i++) begin
            entry_rd_o[i*RfAddrW +: RfAddrW] = rd_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; every consumer of
    // rd_q is qualified by entry_valid_o, which comes from the reset count.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            rd_q[wptr_q] <= push_rd_i;
        end
    end

endmodule

// File: rtl/ibex_rf_write_ctrl.sv
// ----------------------------------------------------------------------------
// ibex_rf_write_ctrl
// Write-side control in front of the flip-flop register file. Merges load
// responses and single-cycle EX results onto the single write port (loads
// first, then a parked EX result, then a direct EX result), parks an EX
// result that collides with a load response in a one-entry skid buffer, and
// reports per-read-port hazards for registers whose value is still pending.
//
// Optional feature: define IBEX_RF_WR_FWD_EN to forward the value being
// written this cycle to the read ports (fwd_a_o/fwd_b_o/fwd_data_o) and drop
// the hazard contributed by that write in the same cycle. Without it the
// forwarding outputs are tied to zero.
//
// Ports:
//   clk_i, rst_ni                  - clock, asynchronous active-low reset
//   ex_valid_i/ex_ready_o          - EX result handshake
//   ex_rd_i, ex_wdata_i            - EX destination and result
//   ld_issue_i/ld_issue_ready_o    - load issue handshake, ld_issue_rd_i dest
//   ld_rvalid_i, ld_rdata_i        - load response (cannot be stalled)
//   ld_err_i                       - load bus error (consumed, no write)
//   raddr_a_i, raddr_b_i           - ID read addresses
//   hazard_a_o, hazard_b_o         - operand still pending
//   fwd_a_o, fwd_b_o, fwd_data_o   - same-cycle forwarding
//   rf_waddr_o, rf_wdata_o, rf_we_o - register-file write port
//   err_o                          - sticky protocol error
// ----------------------------------------------------------------------------
module ibex_rf_write_ctrl
    import ibex_rf_wr_pkg::*;
#(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned LoadDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [4:0]           ex_rd_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    input  logic                 ld_issue_i,
    input  logic [4:0]           ld_issue_rd_i,
    output logic                 ld_issue_ready_o,
    input  logic                 ld_rvalid_i,
    input  logic [DataWidth-1:0] ld_rdata_i,
    input  logic                 ld_err_i,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 hazard_a_o,
    output logic                 hazard_b_o,
    output logic                 fwd_a_o,
    output logic                 fwd_b_o,
    output logic [DataWidth-1:0] fwd_data_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_we_o,
    output logic                 err_o
);

    // Skid buffer and sticky error state
    logic                 skid_valid_q, skid_valid_d;
    rf_addr_t             skid_rd_q, skid_rd_d;
    logic [DataWidth-1:0] skid_wdata_q, skid_wdata_d;
    logic                 err_q, err_d;

    // FIFO interface
    logic                         fifo_full, fifo_empty;
    rf_addr_t                     fifo_head_rd;
    logic [LoadDepth-1:0]         fifo_head_mask;
    logic [LoadDepth-1:0]         fifo_valid;
    logic [LoadDepth*RfAddrW-1:0] fifo_rd;

    wb_src_e              wb_src;
    logic                 ex_fire;
    logic                 ld_wr;
    logic                 rv32e_bad;
    logic [LoadDepth-1:0] ld_excl;
    logic                 skid_seen;

    ibex_rf_ld_fifo #(
        .Depth (LoadDepth)
    ) u_ld_fifo (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .push_i        (ld_issue_i),
        .push_rd_i     (ld_issue_rd_i),
        .pop_i         (ld_rvalid_i),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .head_rd_o     (fifo_head_rd),
        .head_mask_o   (fifo_head_mask),
        .entry_valid_o (fifo_valid),
        .entry_rd_o    (fifo_rd)
    );

    assign ex_ready_o       = ~skid_valid_q;
    assign ld_issue_ready_o = ~fifo_full;
    assign ex_fire          = ex_valid_i & ex_ready_o;
    // A response with no outstanding load has no destination, so it never
    // writes; it only raises err_o.
    assign ld_wr            = ld_rvalid_i & ~ld_err_i & ~fifo_empty;
    assign err_o            = err_q;

    function automatic logic port_hazard(
        input rf_addr_t                     raddr,
        input logic [LoadDepth-1:0]         valid,
        input logic [LoadDepth*RfAddrW-1:0] rds,
        input logic                         skid_v,
        input rf_addr_t                     skid_rd
    );
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < LoadDepth; i++) begin
            if (valid[i] && (rds[i*RfAddrW +: RfAddrW] == raddr)) begin
                hit = 1'b1;
            end
        end
        if (skid_v && (skid_rd == raddr)) begin
            hit = 1'b1;
        end
        return hit && (raddr != '0);
    endfunction

    // Write-port arbitration and output mux
    // NOTE: combinational blocks use blocking assignments and assign every
    // output a default first so no latch is inferred; clocked blocks use
    // non-blocking assignments only.
    always_comb begin
        wb_src     = WB_NONE;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        if (ld_wr) begin
            wb_src     = WB_LOAD;
            rf_waddr_o = fifo_head_rd;
            rf_wdata_o = ld_rdata_i;
        end else if (skid_valid_q) begin
            wb_src     = WB_SKID;
            rf_waddr_o = skid_rd_q;
            rf_wdata_o = skid_wdata_q;
        end else if (ex_fire) begin
            wb_src     = WB_EX;
            rf_waddr_o = ex_rd_i;
            rf_wdata_o = ex_wdata_i;
        end
        // An RV32E core has no x16..x31: such a write is dropped and flagged.
        rv32e_bad = RV32E && (wb_src != WB_NONE) && rf_waddr_o[4];
        rf_we_o   = (wb_src != WB_NONE) && (rf_waddr_o != '0) && !rv32e_bad;
    end

    // Skid buffer: captures EX only when a load response takes the port, and
    // drains on the first cycle the port is free of load writes.
    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_rd_d    = skid_rd_q;
        skid_wdata_d = skid_wdata_q;
        if (skid_valid_q && (wb_src == WB_SKID)) begin
            skid_valid_d = 1'b0;
        end else if (ex_fire && ld_wr) begin
            skid_valid_d = 1'b1;
            skid_rd_d    = ex_rd_i;
            skid_wdata_d = ex_wdata_i;
        end
    end

    always_comb begin
        err_d = err_q
              | (ld_issue_i & fifo_full)
              | (ld_rvalid_i & fifo_empty)
              | rv32e_bad;
    end

    // Hazards and forwarding. A push in this cycle is not yet in fifo_valid,
    // so a same-cycle issue only counts from the next cycle.
    always_comb begin
`ifdef IBEX_RF_WR_FWD_EN
        // The source being written now no longer blocks its register.
        ld_excl    = (rf_we_o && (wb_src == WB_LOAD)) ? fifo_head_mask : '0;
        skid_seen  = skid_valid_q && !(rf_we_o && (wb_src == WB_SKID));
        fwd_a_o    = rf_we_o && (rf_waddr_o == raddr_a_i);
        fwd_b_o    = rf_we_o && (rf_waddr_o == raddr_b_i);
        fwd_data_o = rf_wdata_o;
`else
        ld_excl    = '0;
        skid_seen  = skid_valid_q;
        fwd_a_o    = 1'b0;
        fwd_b_o    = 1'b0;
        fwd_data_o = '0;
`endif
        hazard_a_o = port_hazard(raddr_a_i, fifo_valid & ~ld_excl, fifo_rd,
                                 skid_seen, skid_rd_q);
        hazard_b_o = port_hazard(raddr_b_i, fifo_valid & ~ld_excl, fifo_rd,
                                 skid_seen, skid_rd_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            skid_valid_q <= 1'b0;
            skid_rd_q    <= '0;
            skid_wdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_rd_q    <= skid_rd_d;
            skid_wdata_q <= skid_wdata_d;
            err_q        <= err_d;
        end
    end

endmodule
